// File: rtl/spi_pixel_writer_if.sv
// Byte-stream and framebuffer-side signal bundle for spi_pixel_writer.
// The master side drives received bytes; the slave side is the decoder.
interface spi_pixel_writer_if #(
  parameter int ADDR_BITS = 11
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_first;
  logic                 fb_we;
  logic [ADDR_BITS-1:0] fb_addr;
  logic [23:0]          fb_wdata;
  logic                 swap;
  logic [7:0]           brightness;
  logic                 cmd_error;

  modport master (
    output rx_data, rx_valid, rx_first,
    input  fb_we, fb_addr, fb_wdata, swap, brightness, cmd_error
  );

  modport slave (
    input  rx_data, rx_valid, rx_first,
    output fb_we, fb_addr, fb_wdata, swap, brightness, cmd_error
  );
endinterface

// File: rtl/spi_pixel_writer.sv
// Command decoder sitting behind the SPI slave receiver. Turns a byte stream
// into framebuffer pixel writes, buffer-swap requests and a brightness value.
// Every byte flagged as first-of-transaction is a command and aborts whatever
// was in progress; pixel data streams until the next command.
module spi_pixel_writer #(
  parameter int         ADDR_BITS    = 11,
  parameter logic [7:0] BRIGHT_RESET = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  spi_pixel_writer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, PIX_R, PIX_G, PIX_B, BRIGHT_VAL, DISCARD
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           addr_hi_q, addr_hi_d;
  logic [ADDR_BITS-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]           red_q, red_d;
  logic [7:0]           green_q, green_d;
  logic                 fb_we_q, fb_we_d;
  logic [ADDR_BITS-1:0] fb_addr_q, fb_addr_d;
  logic [23:0]          fb_wdata_q, fb_wdata_d;
  logic                 swap_q, swap_d;
  logic                 cmd_error_q, cmd_error_d;
  logic [7:0]           brightness_q, brightness_d;

  // Next-state and output decode; only cycles carrying a byte change anything.
  always_comb begin
    state_d      = state_q;
    addr_hi_d    = addr_hi_q;
    pix_addr_d   = pix_addr_q;
    red_d        = red_q;
    green_d      = green_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    swap_d       = 1'b0;
    cmd_error_d  = 1'b0;
    brightness_d = brightness_q;

    if (bus.rx_valid) begin
      if (bus.rx_first) begin
        // A command byte restarts decoding; any half-built pixel is dropped
        // simply because PIX_B is never reached for it.
        case (bus.rx_data)
          8'h01:   state_d = ADDR_HI;
          8'h02: begin
            swap_d  = 1'b1;
            state_d = DISCARD;
          end
          8'h03:   state_d = BRIGHT_VAL;
          default: begin
            cmd_error_d = 1'b1;
            state_d     = DISCARD;
          end
        endcase
      end else begin
        case (state_q)
          ADDR_HI: begin
            addr_hi_d = bus.rx_data;
            state_d   = ADDR_LO;
          end
          ADDR_LO: begin
            // 16-bit address from the host; bits above the panel size are dropped.
            pix_addr_d = ADDR_BITS'({addr_hi_q, bus.rx_data});
            state_d    = PIX_R;
          end
          PIX_R: begin
            red_d   = bus.rx_data;
            state_d = PIX_G;
          end
          PIX_G: begin
            green_d = bus.rx_data;
            state_d = PIX_B;
          end
          PIX_B: begin
            fb_we_d    = 1'b1;
            fb_addr_d  = pix_addr_q;
            fb_wdata_d = {red_q, green_q, bus.rx_data};
            pix_addr_d = pix_addr_q + ADDR_BITS'(1);
            state_d    = PIX_R;
          end
          BRIGHT_VAL: begin
            brightness_d = bus.rx_data;
            state_d      = DISCARD;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Register file for the decoder; reset returns everything to idle defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_hi_q    <= '0;
      pix_addr_q   <= '0;
      red_q        <= '0;
      green_q      <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      swap_q       <= 1'b0;
      cmd_error_q  <= 1'b0;
      brightness_q <= BRIGHT_RESET;
    end else begin
      state_q      <= state_d;
      addr_hi_q    <= addr_hi_d;
      pix_addr_q   <= pix_addr_d;
      red_q        <= red_d;
      green_q      <= green_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      swap_q       <= swap_d;
      cmd_error_q  <= cmd_error_d;
      brightness_q <= brightness_d;
    end
  end

  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_wdata   = fb_wdata_q;
  assign bus.swap       = swap_q;
  assign bus.cmd_error  = cmd_error_q;
  assign bus.brightness = brightness_q;

endmodule
